// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared register-file widths, types and a register one-hot helper
package nrisc_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;
  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  function automatic reg_mask_t reg_bit(input reg_addr_t a);
    reg_bit = reg_mask_t'(1) << a;
  endfunction
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// regbank_write_arbiter_if: writeback requests, reservation, hazard query and bank write bus (master drives requests, slave is the arbiter)
interface regbank_write_arbiter_if;
  import nrisc_pkg::*;
  logic      req0_valid, req0_ready, req1_valid, req1_ready;
  reg_addr_t req0_addr, req1_addr;
  reg_data_t req0_data, req1_data;
  logic      rsv_en;
  reg_addr_t rsv_addr;
  reg_addr_t reg1_read, reg2_read;
  logic      rs1_en, rs2_en, hazard;
  reg_mask_t busy;
  logic      regwrite;
  reg_addr_t address;
  reg_data_t writedata;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
           rsv_en, rsv_addr, reg1_read, reg2_read, rs1_en, rs2_en,
    input  req0_ready, req1_ready, hazard, busy, regwrite, address, writedata
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
           rsv_en, rsv_addr, reg1_read, reg2_read, rs1_en, rs2_en,
    output req0_ready, req1_ready, hazard, busy, regwrite, address, writedata
  );
endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin arbiter (clk, rst, req_i[1:0] -> gnt_o[1:0]); pointer names the side that wins a tie
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_o[0] = !rst && req_i[0] && (!req_i[1] || !ptr_q);
    gnt_o[1] = !rst && req_i[1] && (!req_i[0] || ptr_q);
    ptr_d    = gnt_o[0] ? 1'b1 : gnt_o[1] ? 1'b0 : ptr_q;
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares the bank write port between ALU (req0) and load (req1), tracks busy registers and flags read hazards (clock, reset, bus slave)
module regbank_write_arbiter
  import nrisc_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  regbank_write_arbiter_if.slave bus
);
  logic [1:0] gnt;
  logic       regwrite_q, regwrite_d;
  reg_addr_t  address_q, address_d;
  reg_data_t  writedata_q, writedata_d;
  reg_mask_t  busy_q, busy_d;
  rr_arbiter2 u_arb (
    .clk  (clock),
    .rst  (reset),
    .req_i({bus.req1_valid, bus.req0_valid}),
    .gnt_o(gnt)
  );
  // Set is ORed in after the clear so a same-cycle reserve keeps the register busy.
  always_comb begin
    regwrite_d  = |gnt;
    address_d   = gnt[1] ? bus.req1_addr : gnt[0] ? bus.req0_addr : address_q;
    writedata_d = gnt[1] ? bus.req1_data : gnt[0] ? bus.req0_data : writedata_q;
    busy_d      = (busy_q & ~(regwrite_q ? reg_bit(address_q) : '0))
                | (bus.rsv_en ? reg_bit(bus.rsv_addr) : '0);
  end
  always_ff @(posedge clock)
    if (reset) begin
      regwrite_q  <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      busy_q      <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
    end
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  // A write already registered when reset arrives must not reach the bank.
  assign bus.regwrite   = regwrite_q & ~reset;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.busy       = busy_q;
  assign bus.hazard     = (bus.rs1_en & busy_q[bus.reg1_read]) | (bus.rs2_en & busy_q[bus.reg2_read]);
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed vector bench with a behavioural register bank on the write outputs
module tb_regbank_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  regbank_write_arbiter_if bus ();
  regbank_write_arbiter dut (.clock(clk), .reset(rst), .bus(bus));
  logic [7:0] bank [4] = '{default: 8'h00};
  always @(posedge clk) if (bus.regwrite) bank[bus.address] <= bus.writedata;
  typedef struct {
    logic rst, v0; logic [1:0] a0; logic [7:0] d0;
    logic v1; logic [1:0] a1; logic [7:0] d1;
    logic rsv; logic [1:0] ra, r1; logic e1; logic [1:0] r2; logic e2;
    logic rdy0, rdy1, hz, rw; logic [1:0] ad; logic [7:0] wd; logic [3:0] bz; logic [7:0] rd;
  } vec_t;
  vec_t tbl [20];
  task automatic chk(input string n, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", n, i, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    rst = v.rst;
    bus.req0_valid = v.v0; bus.req0_addr = v.a0; bus.req0_data = v.d0;
    bus.req1_valid = v.v1; bus.req1_addr = v.a1; bus.req1_data = v.d1;
    bus.rsv_en = v.rsv; bus.rsv_addr = v.ra;
    bus.reg1_read = v.r1; bus.rs1_en = v.e1; bus.reg2_read = v.r2; bus.rs2_en = v.e2;
  endtask
  initial begin
    //         rst v0 a0 d0     v1 a1 d1     rsv ra r1 e1 r2 e2 | rdy0 rdy1 hz rw ad wd     bz rd
    tbl[0]  = '{1, 1, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
    tbl[1]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
    tbl[2]  = '{0, 1, 1, 8'h55, 1, 2, 8'h0F, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 8'h00, 0, 8'h00};
    tbl[3]  = '{0, 1, 0, 8'hAA, 1, 2, 8'h0F, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 1, 8'h55, 0, 8'h00};
    tbl[4]  = '{0, 1, 0, 8'hAA, 1, 1, 8'h99, 0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 2, 8'h0F, 0, 8'h55};
    tbl[5]  = '{0, 0, 0, 8'h00, 1, 1, 8'h99, 0, 0, 2, 0, 0, 0,   0, 1, 0, 1, 0, 8'hAA, 0, 8'h0F};
    tbl[6]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 8'h99, 0, 8'hAA};
    tbl[7]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 8'h99, 0, 8'h99};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0, 1, 8'h99, 0, 8'h99};
    tbl[9]  = '{0, 0, 0, 8'h00, 1, 3, 8'h3C, 0, 0, 3, 1, 0, 0,   0, 1, 1, 0, 1, 8'h99, 8, 8'h00};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3, 1, 0, 0,   0, 0, 1, 1, 3, 8'h3C, 8, 8'h00};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 3, 8'h3C, 0, 8'h3C};
    tbl[12] = '{0, 1, 2, 8'h22, 0, 0, 8'h00, 1, 2, 2, 0, 2, 1,   1, 0, 0, 0, 3, 8'h3C, 0, 8'h0F};
    tbl[13] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 2, 0, 2, 1,   0, 0, 1, 1, 2, 8'h22, 4, 8'h0F};
    tbl[14] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 2, 0, 2, 1,   0, 0, 1, 0, 2, 8'h22, 4, 8'h22};
    tbl[15] = '{0, 1, 0, 8'hEE, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 8'h22, 6, 8'hAA};
    tbl[16] = '{1, 1, 1, 8'h12, 1, 3, 8'h34, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 8'hEE, 6, 8'hAA};
    tbl[17] = '{0, 1, 1, 8'h12, 1, 3, 8'h34, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 8'h00, 0, 8'hAA};
    tbl[18] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 1, 8'h12, 0, 8'h99};
    tbl[19] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 8'h12, 0, 8'h12};
    drive(tbl[1]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("req0_ready", i, 8'(bus.req0_ready), 8'(tbl[i].rdy0));
      chk("req1_ready", i, 8'(bus.req1_ready), 8'(tbl[i].rdy1));
      chk("hazard",     i, 8'(bus.hazard),     8'(tbl[i].hz));
      chk("regwrite",   i, 8'(bus.regwrite),   8'(tbl[i].rw));
      chk("address",    i, 8'(bus.address),    8'(tbl[i].ad));
      chk("writedata",  i, bus.writedata,      tbl[i].wd);
      chk("busy",       i, 8'(bus.busy),       8'(tbl[i].bz));
      chk("data1",      i, bank[bus.reg1_read], tbl[i].rd);
    end
    // Sustained contention: pointer was left on req1, so grants alternate starting with req1.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_addr = 2'd0; bus.req0_data = 8'h01;
      bus.req1_valid = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'h02;
      bus.rsv_en = 1'b0; bus.rs1_en = 1'b0; bus.rs2_en = 1'b0;
      #1;
      chk("alt_req1_ready", 20 + k, 8'(bus.req1_ready), 8'(k % 2 == 0));
      chk("alt_req0_ready", 20 + k, 8'(bus.req0_ready), 8'(k % 2 == 1));
      if (k > 0) chk("alt_regwrite", 20 + k, 8'(bus.regwrite), 8'h01);
      if (k > 0) chk("alt_writedata", 20 + k, bus.writedata, (k % 2 == 1) ? 8'h02 : 8'h01);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("alt_last_write", 24, bus.writedata, 8'h01);
    @(negedge clk);
    #1;
    chk("alt_idle_regwrite", 25, 8'(bus.regwrite), 8'h00);
    chk("alt_bank0", 25, bank[0], 8'h01);
    chk("alt_bank2", 25, bank[2], 8'h02);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
